vga_scanout: RTL and testbench

//  Downstream consumer of the pixel frame store. Generates VGA raster timing, drives the

---
 rtl/vga_scanout_if.sv | 10 +
 rtl/vga_scanout.sv | 161 ++++++++++++++++
 tb/tb_vga_scanout.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/vga_scanout_if.sv
// Read bus between the scanout engine and the pixel frame store.
// The scanout drives the canvas address; the store answers one clock later.
interface vga_scanout_if;
    logic [9:0] rx;
    logic [9:0] ry;
    logic [2:0] colorCode;

    modport master (output rx, output ry, input colorCode);
    modport slave  (input rx, input ry, output colorCode);
endinterface

// File: rtl/vga_scanout.sv
// VGA raster generator that reads a scaled canvas from the frame store and drives the pins.
// Two pipeline stages: stage 1 samples the raster position, stage 2 merges the store's colour.
module vga_scanout #(
    parameter int       H_ACTIVE    = 640,
    parameter int       H_FP        = 16,
    parameter int       H_SYNC      = 96,
    parameter int       H_BP        = 48,
    parameter int       V_ACTIVE    = 480,
    parameter int       V_FP        = 10,
    parameter int       V_SYNC      = 2,
    parameter int       V_BP        = 33,
    parameter int       CLK_DIV     = 1,
    parameter int       SCALE_SHIFT = 4,
    parameter int       CANVAS_W    = 16,
    parameter int       CANVAS_H    = 16,
    parameter logic [2:0] BORDER_CODE = 3'b001
) (
    input  logic          clk,
    input  logic          reset,
    vga_scanout_if.master store,
    input  logic [9:0]    cursor_x,
    input  logic [9:0]    cursor_y,
    output logic          hsync,
    output logic          vsync,
    output logic          vga_r,
    output logic          vga_g,
    output logic          vga_b,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [10:0] CAN_W_PX = 11'(CANVAS_W << SCALE_SHIFT);
    localparam logic [10:0] CAN_H_PX = 11'(CANVAS_H << SCALE_SHIFT);
    localparam logic [1:0]  DIV_LAST = 2'(CLK_DIV - 1);

    logic [1:0] r_div;
    logic [9:0] r_h;
    logic [9:0] r_v;

    // Stage 1: raster attributes of the pixel whose address the store is fetching
    logic r_active;
    logic r_in_canvas;
    logic r_cur_hit;
    logic r_hs;
    logic r_vs;
    logic r_first;
    logic r_pix_en_d;

    // Stage 2: pin registers
    logic       r_hsync;
    logic       r_vsync;
    logic [2:0] r_rgb;
    logic       r_frame_start;

    logic        w_pix_en;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic [10:0] w_h;
    logic [10:0] w_v;
    logic [9:0]  w_rx;
    logic [9:0]  w_ry;
    logic        w_active;
    logic        w_in_canvas;
    logic        w_cur_hit;
    logic        w_hs;
    logic        w_vs;
    logic        w_first;
    logic [2:0]  w_code;

    assign w_pix_en = (r_div == DIV_LAST);
    assign w_h_wrap = (r_h == H_LAST);
    assign w_v_wrap = (r_v == V_LAST);

    assign w_h  = {1'b0, r_h};
    assign w_v  = {1'b0, r_v};
    assign w_rx = r_h >> SCALE_SHIFT;
    assign w_ry = r_v >> SCALE_SHIFT;

    assign store.rx = w_rx;
    assign store.ry = w_ry;

    assign w_active    = (w_h < H_ACT) && (w_v < V_ACT);
    assign w_in_canvas = (w_h < CAN_W_PX) && (w_v < CAN_H_PX);
    assign w_cur_hit   = w_in_canvas && (w_rx == cursor_x) && (w_ry == cursor_y);
    assign w_hs        = ~((w_h >= HS_BEG) && (w_h <= HS_END));
    assign w_vs        = ~((w_v >= VS_BEG) && (w_v <= VS_END));
    assign w_first     = (r_h == 10'd0) && (r_v == 10'd0);

    // Colour merge per channel: blanking beats border, border beats canvas, cursor inverts
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_code
            assign w_code[gi] = !r_active    ? 1'b0 :
                                !r_in_canvas ? BORDER_CODE[gi] :
                                (store.colorCode[gi] ^ r_cur_hit);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div         <= 2'd0;
            r_h           <= 10'd0;
            r_v           <= 10'd0;
            r_active      <= 1'b0;
            r_in_canvas   <= 1'b0;
            r_cur_hit     <= 1'b0;
            r_hs          <= 1'b0;
            r_vs          <= 1'b0;
            r_first       <= 1'b0;
            r_pix_en_d    <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_rgb         <= 3'b000;
            r_frame_start <= 1'b0;
        end else begin
            r_pix_en_d <= w_pix_en;
            r_div      <= w_pix_en ? 2'd0 : 2'(r_div + 2'd1);

            if (w_pix_en) begin
                r_h <= w_h_wrap ? 10'd0 : 10'(r_h + 10'd1);
                if (w_h_wrap) begin
                    r_v <= w_v_wrap ? 10'd0 : 10'(r_v + 10'd1);
                end
                r_active    <= w_active;
                r_in_canvas <= w_in_canvas;
                r_cur_hit   <= w_cur_hit;
                r_hs        <= w_hs;
                r_vs        <= w_vs;
                r_first     <= w_first;
            end

            // Store data for the stage-1 address is valid exactly on this edge
            if (r_pix_en_d) begin
                r_hsync       <= r_hs;
                r_vsync       <= r_vs;
                r_rgb         <= w_code;
                r_frame_start <= r_first;
            end else begin
                r_frame_start <= 1'b0;
            end
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign vga_r       = r_rgb[2];
    assign vga_g       = r_rgb[1];
    assign vga_b       = r_rgb[0];
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench: a pixel-rate instance with a short frame and a divide-by-2 instance,
// each reading a behavioural frame store with one clock of read latency.
module tb_vga_scanout;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a;
    logic       rst_b;
    logic [9:0] cur_x;
    logic [9:0] cur_y;
    logic       mode_const;

    logic hs_a, vs_a, vr_a, vg_a, vb_a, fs_a;
    logic hs_b, vs_b, vr_b, vg_b, vb_b, fs_b;

    vga_scanout_if bus_a();
    vga_scanout_if bus_b();

    vga_scanout #(.V_ACTIVE(64), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_a (
        .clk(clk), .reset(rst_a), .store(bus_a),
        .cursor_x(cur_x), .cursor_y(cur_y),
        .hsync(hs_a), .vsync(vs_a), .vga_r(vr_a), .vga_g(vg_a), .vga_b(vb_a),
        .frame_start(fs_a)
    );

    vga_scanout #(.V_ACTIVE(64), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(2)) dut_b (
        .clk(clk), .reset(rst_b), .store(bus_b),
        .cursor_x(cur_x), .cursor_y(cur_y),
        .hsync(hs_b), .vsync(vs_b), .vga_r(vr_b), .vga_g(vg_b), .vga_b(vb_b),
        .frame_start(fs_b)
    );

    function automatic logic [2:0] store_fn(input logic [9:0] x, input logic [9:0] y);
        return mode_const ? 3'b110 : {x[0], y[0], 1'b1};
    endfunction

    always @(posedge clk) begin
        bus_a.colorCode <= store_fn(bus_a.rx, bus_a.ry);
        bus_b.colorCode <= store_fn(bus_b.rx, bus_b.ry);
    end

    int n_asrt = 0;
    int n_fail = 0;
    int k = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        $display("[k=%0d] %s obs=%0h exp=%0h", k, tag, obs, exp);
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        k = k + 1;
    endtask

    // Pixel p = v*800 + h of instance A is on the pins after posedge p+2 of the run
    task automatic goto_a(input int h, input int v);
        while (k < v * 800 + h + 2) tick();
    endtask

    task automatic pix_a(input int h, input int v, input logic [2:0] exp);
        goto_a(h, v);
        chk($sformatf("a_pix_%0d_%0d", h, v), 32'({vr_a, vg_a, vb_a}), 32'(exp));
    endtask

    initial begin
        int   p, lows, f1, f2, fsc, fsp;
        logic prev;

        rst_a = 1'b1; rst_b = 1'b1;
        cur_x = 10'd20; cur_y = 10'd0; mode_const = 1'b0;
        repeat (3) @(negedge clk);
        chk("a_rst_hsync", 32'(hs_a), 32'd1);
        chk("a_rst_vsync", 32'(vs_a), 32'd1);
        chk("a_rst_rgb", 32'({vr_a, vg_a, vb_a}), 32'd0);
        chk("a_rst_fs", 32'(fs_a), 32'd0);

        rst_a = 1'b0; k = 0;
        tick(); chk("a_fs_k1", 32'(fs_a), 32'd0);
        tick(); chk("a_fs_k2", 32'(fs_a), 32'd1);
        chk("a_pix_0_0", 32'({vr_a, vg_a, vb_a}), 32'd1);
        tick(); chk("a_fs_k3", 32'(fs_a), 32'd0);

        // Two full lines of hsync behaviour
        prev = hs_a; lows = 0; f1 = -1; f2 = -1; fsc = 0;
        while (k < 1601) begin
            tick();
            p = k - 2;
            if (hs_a == 1'b0) begin
                lows++;
                if (prev) begin
                    if (f1 < 0) f1 = p;
                    else if (f2 < 0) f2 = p;
                end
            end
            prev = hs_a;
            if (fs_a) fsc++;
            if (p == 15) chk("a_pix_15_0", 32'({vr_a, vg_a, vb_a}), 32'd1);
            if (p == 16) chk("a_pix_16_0", 32'({vr_a, vg_a, vb_a}), 32'd5);
        end
        chk("a_hs_low_count", 32'(lows), 32'd192);
        chk("a_hs_fall1", 32'(f1), 32'd656);
        chk("a_hs_fall2", 32'(f2), 32'd1456);
        chk("a_fs_in_lines", 32'(fsc), 32'd0);

        pix_a(16, 10, 3'b101);
        pix_a(300, 10, 3'b001);
        pix_a(700, 10, 3'b000);
        chk("a_vsync_line10", 32'(vs_a), 32'd1);
        pix_a(255, 17, 3'b111);
        pix_a(40, 20, 3'b011);

        goto_a(0, 30);
        mode_const = 1'b1; cur_x = 10'd2; cur_y = 10'd3;
        pix_a(32, 47, 3'b110);
        pix_a(31, 48, 3'b110);
        pix_a(32, 48, 3'b001);
        pix_a(47, 48, 3'b001);
        pix_a(48, 48, 3'b110);
        pix_a(40, 55, 3'b001);
        goto_a(0, 56);
        cur_x = 10'd20;
        pix_a(40, 60, 3'b110);
        pix_a(47, 63, 3'b110);
        pix_a(32, 64, 3'b000);

        // Vertical blanking and frame_start period into the next frame
        lows = 0; f1 = -1; fsc = 0; fsp = -1;
        while (k < 54400 + 3) begin
            tick();
            p = k - 2;
            if (vs_a == 1'b0) begin
                lows++;
                if (f1 < 0) f1 = p;
            end
            if (fs_a) begin
                fsc++;
                fsp = p;
            end
        end
        chk("a_vs_low_count", 32'(lows), 32'd1600);
        chk("a_vs_first", 32'(f1), 32'd52000);
        chk("a_fs_count", 32'(fsc), 32'd1);
        chk("a_fs_period", 32'(fsp), 32'd54400);

        // Divide-by-2 instance
        mode_const = 1'b0;
        rst_b = 1'b0; k = 0;
        prev = hs_b; f1 = -1; f2 = -1;
        while (k < 3000) begin
            tick();
            if (hs_b == 1'b0 && prev) begin
                if (f1 < 0) f1 = k;
                else if (f2 < 0) f2 = k;
            end
            prev = hs_b;
            if (k == 3) chk("b_fs_k3", 32'(fs_b), 32'd1);
            if (k == 4) chk("b_fs_k4", 32'(fs_b), 32'd0);
            if (k == 33 || k == 34)
                chk($sformatf("b_pix15_k%0d", k), 32'({vr_b, vg_b, vb_b}), 32'd1);
            if (k == 35 || k == 36)
                chk($sformatf("b_pix16_k%0d", k), 32'({vr_b, vg_b, vb_b}), 32'd5);
        end
        chk("b_hs_fall1", 32'(f1), 32'd1315);
        chk("b_hs_fall2", 32'(f2), 32'd2915);

        // Mid-frame reset with the raster at h=400, v=2
        while (k < 4000) tick();
        chk("b_pre_rst_rgb", 32'({vr_b, vg_b, vb_b}), 32'd1);
        rst_b = 1'b1;
        tick();
        chk("b_rst_rgb", 32'({vr_b, vg_b, vb_b}), 32'd0);
        chk("b_rst_hsync", 32'(hs_b), 32'd1);
        chk("b_rst_vsync", 32'(vs_b), 32'd1);
        rst_b = 1'b0; k = 0;
        prev = hs_b; f1 = -1;
        while (k < 1400) begin
            tick();
            if (hs_b == 1'b0 && prev && f1 < 0) f1 = k;
            prev = hs_b;
            if (k == 3) chk("b2_fs_k3", 32'(fs_b), 32'd1);
            if (k == 35) chk("b2_pix16", 32'({vr_b, vg_b, vb_b}), 32'd5);
        end
        chk("b2_hs_fall1", 32'(f1), 32'd1315);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
